// File: rtl/cmp_led_sequencer.sv
// cmp_led_sequencer
//   Queues 2-bit operand pairs in a 4-entry FIFO and displays each comparison
//   result on an RGB indicator: red = a>b, green = a==b, blue = a<b.
//   Each result is held for HOLD_CYCLES cycles, followed by GAP_CYCLES blank
//   cycles before the next queued result is shown.
//
// Parameters
//   HOLD_CYCLES  cycles a result is shown (1..255)
//   GAP_CYCLES   blank cycles between consecutive results (1..255)
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   in_valid    a/b pair is valid this cycle
//   a, b        unsigned operands
//   in_ready    FIFO has room; a pair is accepted when in_valid & in_ready
//   red/green/blue  result currently shown (all 0 when blank or idle)
//   busy        FSM not idle or FIFO non-empty
//   done_count  number of results shown so far, wraps at 256
module cmp_led_sequencer #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       in_ready,
  output logic       red,
  output logic       green,
  output logic       blue,
  output logic       busy,
  output logic [7:0] done_count
);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES);
  localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES);

  state_t     state, state_next;
  logic [7:0] cnt, cnt_next;
  logic [2:0] rgb, rgb_next;

  logic [3:0] mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic       push, pop;
  logic [1:0] head_a, head_b;

  // Readiness depends only on stored occupancy, so a full FIFO refuses a
  // push even on an edge that also pops.
  assign in_ready = (count < 3'd4);
  assign push     = in_valid & in_ready;
  assign {head_a, head_b} = mem[rd_ptr];

  assign {red, green, blue} = rgb;
  assign busy = (state != IDLE) || (count != 3'd0);

  // cnt counts down the remaining cycles of the current state; the state is
  // left on the edge where cnt reads 1.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    rgb_next   = rgb;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (count != 3'd0) begin
          pop        = 1'b1;
          state_next = SHOW;
          cnt_next   = HOLD_LOAD;
          rgb_next   = {head_a > head_b, head_a == head_b, head_a < head_b};
        end
      end
      SHOW: begin
        if (cnt == 8'd1) begin
          state_next = GAP;
          cnt_next   = GAP_LOAD;
          rgb_next   = '0;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      GAP: begin
        if (cnt == 8'd1) begin
          if (count != 3'd0) begin
            pop        = 1'b1;
            state_next = SHOW;
            cnt_next   = HOLD_LOAD;
            rgb_next   = {head_a > head_b, head_a == head_b, head_a < head_b};
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        rgb_next   = '0;
      end
    endcase
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {a, b};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rgb        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      done_count <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      rgb   <= rgb_next;
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + 2'd1;
        done_count <= done_count + 8'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_led_sequencer.sv
// Self-checking bench for cmp_led_sequencer. The reference model keeps every
// accepted pair with its acceptance edge and its computed display-start edge
// (start = max(accept+1, previous start + HOLD + GAP)); all expected outputs
// are derived from those timestamps.
module tb_cmp_led_sequencer;

  localparam int H = 4;
  localparam int G = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] a = '0;
  logic [1:0] b = '0;
  logic       in_ready, red, green, blue, busy;
  logic [7:0] done_count;

  cmp_led_sequencer #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .in_ready(in_ready), .red(red), .green(green), .blue(blue),
    .busy(busy), .done_count(done_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int         q_e[$];
  int         q_s[$];
  logic [1:0] q_a[$];
  logic [1:0] q_b[$];

  logic [2:0] exp_rgb;
  logic [7:0] exp_done;
  logic       exp_busy, exp_ready;
  logic       last_acc;

  // Expected outputs as seen just after edge t.
  function automatic void model_eval(input int t);
    int done;
    int occ;
    done = 0;
    occ = 0;
    exp_rgb = '0;
    exp_busy = 1'b0;
    foreach (q_s[i]) begin
      if (q_s[i] <= t) done++;
      if (q_s[i] <= t && t < q_s[i] + H)
        exp_rgb = {q_a[i] > q_b[i], q_a[i] == q_b[i], q_a[i] < q_b[i]};
      if (q_e[i] <= t && t < q_s[i] + H + G) exp_busy = 1'b1;
      if (q_e[i] <= t && t < q_s[i]) occ++;
    end
    exp_done = 8'(done);
    exp_ready = (occ < 4);
  endfunction

  task automatic step(input logic v, input logic [1:0] av, input logic [1:0] bv);
    int s;
    model_eval(cyc);
    last_acc = v && exp_ready;
    in_valid = v;
    a = av;
    b = bv;
    @(posedge clk);
    cyc++;
    if (last_acc) begin
      s = cyc + 1;
      if (q_s.size() > 0 && q_s[$] + H + G > s) s = q_s[$] + H + G;
      q_e.push_back(cyc);
      q_s.push_back(s);
      q_a.push_back(av);
      q_b.push_back(bv);
    end
    #1;
    in_valid = 1'b0;
    model_eval(cyc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    a = 2'($urandom);
    b = 2'($urandom);
    @(posedge clk);
    cyc++;
    q_e.delete();
    q_s.delete();
    q_a.delete();
    q_b.delete();
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    model_eval(cyc);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({red, green, blue, done_count, busy, in_ready} !== {3'b000, 8'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state got rgb=%b done=%0d busy=%b rdy=%b exp rgb=000 done=0 busy=0 rdy=1",
               {red, green, blue}, done_count, busy, in_ready);
    end
    step(1'b0, 2'd0, 2'd0);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ignores_valid got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    step(1'b1, 2'd2, 2'd1);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 2'd0, 2'd0);
      checks++;
      if ({red, green, blue, done_count, busy, in_ready} !== {exp_rgb, exp_done, exp_busy, exp_ready}) begin
        errors++;
        $display("FAIL single t=%0d got %b/%0d/%b/%b exp %b/%0d/%b/%b", i,
                 {red, green, blue}, done_count, busy, in_ready, exp_rgb, exp_done, exp_busy, exp_ready);
      end
      if (i < H) begin
        checks++;
        if ({red, green, blue} !== 3'b100) begin
          errors++;
          $display("FAIL single_red cycle=%0d got %b exp 100", i + 1, {red, green, blue});
        end
      end
    end
    checks++;
    if ({red, green, blue, done_count, busy} !== {3'b000, 8'd1, 1'b0}) begin
      errors++;
      $display("FAIL single_end got rgb=%b done=%0d busy=%b exp rgb=000 done=1 busy=0",
               {red, green, blue}, done_count, busy);
    end
  endtask

  task automatic test_eq_lt();
    do_reset();
    step(1'b1, 2'd3, 2'd3);
    step(1'b1, 2'd0, 2'd3);
    for (int i = 2; i < 14; i++) begin
      step(1'b0, 2'd0, 2'd0);
      checks++;
      if ({red, green, blue, done_count, busy, in_ready} !== {exp_rgb, exp_done, exp_busy, exp_ready}) begin
        errors++;
        $display("FAIL eq_lt t=%0d got %b/%0d/%b/%b exp %b/%0d/%b/%b", i,
                 {red, green, blue}, done_count, busy, in_ready, exp_rgb, exp_done, exp_busy, exp_ready);
      end
      // Offsets from the first push: green 1..4, blank 5, blue 6..9.
      if (i == 4 || i == 5 || i == 6) begin
        checks++;
        if ({red, green, blue} !== ((i == 4) ? 3'b010 : (i == 5) ? 3'b000 : 3'b001)) begin
          errors++;
          $display("FAIL eq_lt_fixed t=%0d got %b", i, {red, green, blue});
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] pa [6];
    logic [1:0] pb [6];
    int idx;
    logic saw_block;
    pa = '{2'd1, 2'd2, 2'd0, 2'd3, 2'd1, 2'd0};
    pb = '{2'd0, 2'd2, 2'd1, 2'd2, 2'd3, 2'd0};
    idx = 0;
    saw_block = 1'b0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if (idx < 6 && in_ready === 1'b0) saw_block = 1'b1;
      step(idx < 6, (idx < 6) ? pa[idx] : 2'd0, (idx < 6) ? pb[idx] : 2'd0);
      if (last_acc) idx++;
      checks++;
      if ({red, green, blue, done_count, busy, in_ready} !== {exp_rgb, exp_done, exp_busy, exp_ready}) begin
        errors++;
        $display("FAIL backpressure t=%0d got %b/%0d/%b/%b exp %b/%0d/%b/%b", i,
                 {red, green, blue}, done_count, busy, in_ready, exp_rgb, exp_done, exp_busy, exp_ready);
      end
    end
    checks++;
    if ({saw_block, done_count, busy} !== {1'b1, 8'd6, 1'b0}) begin
      errors++;
      $display("FAIL backpressure_end got blocked=%b done=%0d busy=%b exp blocked=1 done=6 busy=0",
               saw_block, done_count, busy);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 2'(i), 2'(3 - i));
    step(1'b1, 2'd3, 2'd0);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_before_pop got rdy=%b exp 0", in_ready);
    end
    step(1'b1, 2'd3, 2'd0);
    checks++;
    if ({in_ready, red, green, blue} !== {1'b1, 3'b001}) begin
      errors++;
      $display("FAIL full_pop_edge got rdy=%b rgb=%b exp rdy=1 rgb=001", in_ready, {red, green, blue});
    end
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 2'd0, 2'd0);
      checks++;
      if ({red, green, blue, done_count, busy, in_ready} !== {exp_rgb, exp_done, exp_busy, exp_ready}) begin
        errors++;
        $display("FAIL full_pop t=%0d got %b/%0d/%b/%b exp %b/%0d/%b/%b", i,
                 {red, green, blue}, done_count, busy, in_ready, exp_rgb, exp_done, exp_busy, exp_ready);
      end
    end
    checks++;
    if (done_count !== 8'd5) begin
      errors++;
      $display("FAIL full_pop_count got %0d exp 5", done_count);
    end
  endtask

  task automatic test_reset_mid_show();
    do_reset();
    step(1'b1, 2'd3, 2'd1);
    step(1'b1, 2'd1, 2'd1);
    step(1'b1, 2'd0, 2'd2);
    step(1'b1, 2'd2, 2'd0);
    do_reset();
    checks++;
    if ({red, green, blue, in_ready, busy, done_count} !== {3'b000, 1'b1, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL mid_show_reset got rgb=%b rdy=%b busy=%b done=%0d exp rgb=000 rdy=1 busy=0 done=0",
               {red, green, blue}, in_ready, busy, done_count);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 2'd0, 2'd0);
      checks++;
      if ({red, green, blue, done_count, busy, in_ready} !== {3'b000, 8'd0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL mid_show_stale t=%0d got %b/%0d/%b/%b exp 000/0/0/1", i,
                 {red, green, blue}, done_count, busy, in_ready);
      end
    end
  endtask

  task automatic test_random();
    int dens;
    dens = 1;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) dens = int'($urandom_range(0, 4));
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
        checks++;
        if ({red, green, blue, done_count, busy, in_ready} !== {3'b000, 8'd0, 1'b0, 1'b1}) begin
          errors++;
          $display("FAIL random_reset t=%0d got %b/%0d/%b/%b exp 000/0/0/1", i,
                   {red, green, blue}, done_count, busy, in_ready);
        end
      end else begin
        step(int'($urandom_range(0, 3)) < dens, 2'($urandom), 2'($urandom));
        checks++;
        if ({red, green, blue, done_count, busy, in_ready} !== {exp_rgb, exp_done, exp_busy, exp_ready}) begin
          errors++;
          $display("FAIL random t=%0d got %b/%0d/%b/%b exp %b/%0d/%b/%b", i,
                   {red, green, blue}, done_count, busy, in_ready, exp_rgb, exp_done, exp_busy, exp_ready);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int pushed;
    pushed = 0;
    do_reset();
    for (int i = 0; i < 256 * (H + G) + 20; i++) begin
      step(pushed < 256, 2'($urandom), 2'($urandom));
      if (last_acc) pushed++;
      checks++;
      if ({red, green, blue, done_count, busy, in_ready} !== {exp_rgb, exp_done, exp_busy, exp_ready}) begin
        errors++;
        $display("FAIL wrap t=%0d got %b/%0d/%b/%b exp %b/%0d/%b/%b", i,
                 {red, green, blue}, done_count, busy, in_ready, exp_rgb, exp_done, exp_busy, exp_ready);
      end
    end
    checks++;
    if ({done_count, busy} !== {8'd0, 1'b0} || q_s.size() != 256) begin
      errors++;
      $display("FAIL wrap_end got done=%0d busy=%b shown=%0d exp done=0 busy=0 shown=256",
               done_count, busy, q_s.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_eq_lt();
    test_backpressure();
    test_full_pop();
    test_reset_mid_show();
    test_random();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmp_led_sequencer.md
CMP_LED_SEQUENCER -- requirements
Module: cmp_led_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter HOLD_CYCLES, default 4: number of cycles a result is shown on the RGB outputs; legal range 1..255.
REQ-003 Parameter GAP_CYCLES, default 1: number of blank cycles between consecutive results; legal range 1..255.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  the request pair on a/b is valid.
REQ-007 a  input  2  first unsigned operand.
REQ-008 b  input  2  second unsigned operand.
REQ-009 in_ready  output  1  the block can accept a pair this cycle.
REQ-010 red  output  1  the result being shown is a>b.
REQ-011 green  output  1  the result being shown is a==b.
REQ-012 blue  output  1  the result being shown is a<b.
REQ-013 busy  output  1  the block is not idle or its queue is non-empty.
REQ-014 done_count  output  8  number of results shown so far; wraps at 256.

Function
REQ-015 A pair SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
- Accepted pairs go into a 4-entry FIFO, stored in order.
REQ-016 in_ready SHALL be 1 exactly when the FIFO holds fewer than 4 entries.
- in_ready SHALL NOT depend on a pop happening in the same cycle.
- When the FIFO is full, a same-cycle pop SHALL NOT allow a push.
REQ-017 A push and a pop on the same edge SHALL leave the FIFO occupancy unchanged.
- Read and write pointers SHALL wrap modulo 4.
REQ-018 The FSM SHALL have exactly three states: IDLE, SHOW and GAP.
REQ-019 In IDLE with the FIFO non-empty:
- the FSM SHALL pop the head entry on the next edge and enter SHOW;
- on that same edge it SHALL register the result as red=(a>b), green=(a==b), blue=(a<b), comparing unsigned.
REQ-020 In SHOW, exactly one of red/green/blue SHALL be 1.
- The FSM SHALL stay in SHOW for exactly HOLD_CYCLES cycles, then enter GAP.
REQ-021 In GAP, red, green and blue SHALL all be 0 for exactly GAP_CYCLES cycles. On the last GAP edge:
- if the FIFO is non-empty, the FSM SHALL pop and enter SHOW directly with the new result;
- otherwise it SHALL enter IDLE.
REQ-022 In IDLE, red, green and blue SHALL all be 0.
REQ-023 Latency: a pair accepted on edge E0 into an empty FIFO while in IDLE SHALL appear on the RGB outputs from edge E0+1 through edge E0+HOLD_CYCLES.
REQ-024 done_count SHALL increment by 1 on every edge that enters SHOW, wrapping from 255 to 0.
REQ-025 busy SHALL be 1 whenever the state is not IDLE or the FIFO is non-empty.
REQ-026 Pairs SHALL be displayed strictly in acceptance order; none SHALL be dropped or duplicated.
REQ-027 A single hold/gap cycle counter, 8 bits wide, SHALL be reloaded on every state entry.

Reset
REQ-028 While rst=1 at a rising edge, the following SHALL hold after that edge:
- state=IDLE;
- FIFO empty, with both pointers at 0;
- red=green=blue=0;
- done_count=0, busy=0, in_ready=1.
REQ-029 Reset asserted in any state, including mid-SHOW, mid-GAP or with a full FIFO, SHALL discard all queued pairs and take priority over any push or pop on the same edge.
REQ-030 in_valid SHALL be ignored on any edge where rst=1.

Verification
REQ-031 Single pair: reset, then push a=2,b=1 at E0 -> red=1 for cycles E0+1..E0+4, then 0; done_count=1; busy=0 after the gap.
REQ-032 Equality and less-than:
- push a=3,b=3 -> green only, for 4 cycles;
- then push a=0,b=3 -> blue only, after a 1-cycle blank.
REQ-033 Backpressure: hold in_valid=1 with 6 distinct pairs -> in_ready drops to 0 once 4 entries are queued; all 6 results are shown in order, each 4 on and 1 off; done_count=6.
REQ-034 Reset mid-SHOW with 3 pairs queued -> on the next edge RGB=000, in_ready=1, busy=0 and done_count=0; no stale result appears afterwards.
REQ-035 Full-FIFO push attempt coinciding with a GAP-to-SHOW pop -> the pair is not accepted; occupancy goes 4 to 3.
REQ-036 Wrap: display 256 pairs -> done_count reads 0 after the 256th SHOW entry.
